// File: rtl/spi_write_master.sv
// spi_write_master: SPI mode-0 write-only master. One DATA_W-bit word per CS frame,
// accepted over a valid/ready handshake and shifted out on MOSI under SCLK.
// Frame sequence: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE, each phase CLK_DIV cycles.
// Every pin and handshake output is a flop, so no input reaches a pin combinationally.
// Optional build macro: SPI_WR_LSB_FIRST_EN (shift LSB first instead of MSB first).
module spi_write_master #(
   parameter int DATA_W  = 16,
   parameter int CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   output logic              busy,
   output logic              done,
   output logic              SCLK,
   output logic              MOSI,
   output logic              CS
);

   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam int BIT_W = $clog2(DATA_W + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic              cs_q, cs_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              wr_ready_q, wr_ready_d;
   logic              accept;
   logic              phase_end;
   logic              in_frame;

   // Bit presented on MOSI for a given shift-register content.
   function automatic logic wire_bit(input logic [DATA_W-1:0] w);
`ifdef SPI_WR_LSB_FIRST_EN
      return w[0];
`else
      return w[DATA_W-1];
`endif
   endfunction

   // Shift-register content after one bit has been sent.
   function automatic logic [DATA_W-1:0] shift_once(input logic [DATA_W-1:0] w);
`ifdef SPI_WR_LSB_FIRST_EN
      return {1'b0, w[DATA_W-1:1]};
`else
      return {w[DATA_W-2:0], 1'b0};
`endif
   endfunction

   assign accept    = wr_valid & wr_ready_q;
   assign phase_end = (div_q == DIV_LAST);

   // Next-state, counters, shift register and registered-output values.
   always_comb begin
      state_d = state_q;
      div_d   = div_q + DIV_W'(1);
      bit_d   = bit_q;
      shreg_d = shreg_q;
      sclk_d  = sclk_q;
      case (state_q)
         ST_IDLE: begin
            div_d  = {DIV_W{1'b0}};
            sclk_d = 1'b0;
            if (accept) begin
               shreg_d = wr_data;
               bit_d   = {BIT_W{1'b0}};
               state_d = ST_SETUP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETUP: begin
            if (phase_end) begin
               div_d   = {DIV_W{1'b0}};
               sclk_d  = 1'b1;
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_SETUP;
            end
         end
         ST_SHIFT: begin
            if (phase_end && sclk_q) begin
               // Falling edge: data advances here so it is stable at the next rise.
               div_d  = {DIV_W{1'b0}};
               sclk_d = 1'b0;
               if (bit_q == BIT_LAST) begin
                  bit_d   = {BIT_W{1'b0}};
                  state_d = ST_HOLD;
               end else begin
                  bit_d   = bit_q + BIT_W'(1);
                  shreg_d = shift_once(shreg_q);
               end
            end else if (phase_end) begin
               div_d  = {DIV_W{1'b0}};
               sclk_d = 1'b1;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_HOLD: begin
            if (phase_end) begin
               div_d   = {DIV_W{1'b0}};
               state_d = ST_GAP;
            end else begin
               state_d = ST_HOLD;
            end
         end
         ST_GAP: begin
            if (phase_end) begin
               div_d   = {DIV_W{1'b0}};
               state_d = ST_IDLE;
            end else begin
               state_d = ST_GAP;
            end
         end
         default: begin
            state_d = ST_IDLE;
            div_d   = {DIV_W{1'b0}};
            bit_d   = {BIT_W{1'b0}};
            sclk_d  = 1'b0;
         end
      endcase

      in_frame   = (state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD);
      cs_d       = ~in_frame;
      mosi_d     = in_frame ? wire_bit(shreg_d) : 1'b0;
      busy_d     = (state_d != ST_IDLE);
      wr_ready_d = (state_d == ST_IDLE);
      done_d     = (state_d == ST_GAP) && (div_d == DIV_LAST);
   end

   // State, counters, shift register and output flops; reset aborts any frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         div_q      <= {DIV_W{1'b0}};
         bit_q      <= {BIT_W{1'b0}};
         shreg_q    <= {DATA_W{1'b0}};
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         cs_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wr_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         shreg_q    <= shreg_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         cs_q       <= cs_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         wr_ready_q <= wr_ready_d;
      end
   end

   assign wr_ready = wr_ready_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign SCLK     = sclk_q;
   assign MOSI     = mosi_q;
   assign CS       = cs_q;

endmodule

// File: tb/tb_spi_write_master.sv
// tb_spi_write_master: scoreboard bench for spi_write_master at DATA_W=16, CLK_DIV=4.
// A bus-level slave captures bits on SCLK rise; a cycle monitor measures CS timing,
// done pulses and accept spacing. Honours SPI_WR_LSB_FIRST_EN for the bit-order model.
module tb_spi_write_master;

   localparam int DW  = 16;
   localparam int DIV = 4;
   localparam int CS_LOW_CYC  = (2 * DW + 1) * DIV;       // 132
   localparam int ACC_PERIOD  = (2 * DW + 2) * DIV + 1;   // 137
   localparam int DONE_OFFSET = (2 * DW + 2) * DIV;       // done seen 136 cycles after accept
   localparam int CS_HIGH_B2B = ACC_PERIOD - CS_LOW_CYC;  // GAP plus the single IDLE accept cycle

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_valid = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_ready, busy, done, SCLK, MOSI, CS;

   int n_checks = 0;
   int n_fail   = 0;

   spi_write_master #(.DATA_W(DW), .CLK_DIV(DIV)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
      .wr_ready(wr_ready), .busy(busy), .done(done),
      .SCLK(SCLK), .MOSI(MOSI), .CS(CS)
   );

   always #5 clk = ~clk;

   // Scoreboard queues: expected words pushed at send, captured frames pushed by monitor.
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] rx_q[$];
   int            rxn_q[$];

   // Slave model: shift in MOSI on every SCLK rise while selected, first bit ends up at MSB.
   logic [DW-1:0] rx = '0;
   int            rx_n = 0;
   always @(negedge CS or posedge SCLK) begin
      if (!CS && SCLK) begin
         rx   = {rx[DW-2:0], MOSI};
         rx_n = rx_n + 1;
      end else if (!SCLK) begin
         rx   = '0;
         rx_n = 0;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Cycle monitor, sampled on the falling clock edge.
   int  done_total = 0, frames_total = 0, acc_total = 0;
   int  acc_last = 0, acc_prev = 0, done_cyc = 0;
   int  run = 0, last_cs_low = 0, last_cs_high = 0;
   int  busy_err = 0, pin_err = 0, mosi_err = 0;
   logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         run = 0; prev_cs = 1'b1; prev_sclk = 1'b0; prev_mosi = 1'b0;
      end else begin
         if (wr_valid && wr_ready) begin
            acc_prev = acc_last; acc_last = cyc; acc_total = acc_total + 1;
         end
         if (done) begin
            done_total = done_total + 1; done_cyc = cyc;
            if (!busy) busy_err = busy_err + 1;
         end
         if (!CS && !busy) busy_err = busy_err + 1;
         if (CS && (SCLK || MOSI)) pin_err = pin_err + 1;
         if (SCLK && !prev_sclk && (MOSI !== prev_mosi)) mosi_err = mosi_err + 1;
         if (CS != prev_cs) begin
            if (CS) begin
               last_cs_low = run;
               rx_q.push_back(rx);
               rxn_q.push_back(rx_n);
               frames_total = frames_total + 1;
            end else begin
               last_cs_high = run;
            end
            run = 1;
         end else begin
            run = run + 1;
         end
         prev_cs = CS; prev_sclk = SCLK; prev_mosi = MOSI;
      end
   end

   // Order in which a word's bits arrive at the slave (captured MSB-first).
   function automatic logic [DW-1:0] on_wire(input logic [DW-1:0] w);
      logic [DW-1:0] r;
`ifdef SPI_WR_LSB_FIRST_EN
      for (int i = 0; i < DW; i++) r[i] = w[DW-1-i];
`else
      r = w;
`endif
      return r;
   endfunction

   // Wait for IDLE, present one word for a single cycle, record its expectation.
   task automatic send_word(input logic [DW-1:0] w);
      int k;
      k = 0;
      while (!wr_ready && k < 400) begin
         @(negedge clk); k++;
      end
      @(posedge clk); #1;
      wr_valid = 1'b1; wr_data = w;
      exp_q.push_back(on_wire(w));
      @(posedge clk); #1;
      wr_valid = 1'b0;
   endtask

   // Wait until the monitor has seen the given number of completed frames.
   task automatic wait_frames(input int target, input string tag);
      int k;
      k = 0;
      while (frames_total < target && k < 400) begin
         @(negedge clk); #1; k++;
      end
      n_checks++;
      if (frames_total < target) begin
         n_fail++;
         $display("FAIL %s_timeout: frames=%0d required=%0d", tag, frames_total, target);
      end
      repeat (3 * DIV) @(negedge clk);
      #1;
   endtask

   // Pop one captured frame and one expectation and compare word and bit count.
   task automatic score_frame(input string tag);
      logic [DW-1:0] got, exp;
      int n;
      n_checks++;
      if (rx_q.size() == 0 || exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s_data: captured=%0d expected=%0d entries", tag, rx_q.size(), exp_q.size());
      end else begin
         got = rx_q.pop_front(); exp = exp_q.pop_front(); n = rxn_q.pop_front();
         if (got !== exp) begin
            n_fail++;
            $display("FAIL %s_data: got=%h required=%h", tag, got, exp);
         end
         n_checks++;
         if (n !== DW) begin
            n_fail++;
            $display("FAIL %s_rises: got=%0d required=%0d", tag, n, DW);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({CS, SCLK, MOSI, busy, done, wr_ready} !== 6'b100000) begin
         n_fail++;
         $display("FAIL reset_pins: got=%b required=100000", {CS, SCLK, MOSI, busy, done, wr_ready});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (wr_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready_early: got=%b required=0", wr_ready);
      end
      @(negedge clk);
      n_checks++;
      if ({wr_ready, CS, busy} !== 3'b110) begin
         n_fail++;
         $display("FAIL reset_ready: got=%b required=110", {wr_ready, CS, busy});
      end
   endtask

   task automatic test_single();
      int d0, f0;
      d0 = done_total; f0 = frames_total;
      send_word(16'hA5C3);
      wait_frames(f0 + 1, "single");
      score_frame("single");
      n_checks++;
      if (last_cs_low !== CS_LOW_CYC) begin
         n_fail++;
         $display("FAIL single_cs_low: got=%0d required=%0d", last_cs_low, CS_LOW_CYC);
      end
      n_checks++;
      if (done_total - d0 !== 1) begin
         n_fail++;
         $display("FAIL single_done_count: got=%0d required=1", done_total - d0);
      end
      n_checks++;
      if (done_cyc - acc_last !== DONE_OFFSET) begin
         n_fail++;
         $display("FAIL single_done_time: got=%0d required=%0d", done_cyc - acc_last, DONE_OFFSET);
      end
      n_checks++;
      if ({busy, CS, wr_ready} !== 3'b011) begin
         n_fail++;
         $display("FAIL single_idle_after: got=%b required=011", {busy, CS, wr_ready});
      end
   endtask

   task automatic test_back_to_back();
      int d0, f0, a0, k;
      d0 = done_total; f0 = frames_total; a0 = acc_total;
      k = 0;
      while (!wr_ready && k < 400) begin
         @(negedge clk); k++;
      end
      @(posedge clk); #1;
      wr_valid = 1'b1; wr_data = 16'h0001;
      exp_q.push_back(on_wire(16'h0001));
      @(posedge clk); #1;
      wr_data = 16'h8000;
      exp_q.push_back(on_wire(16'h8000));
      k = 0;
      while (acc_total < a0 + 2 && k < 400) begin
         @(negedge clk); #1; k++;
      end
      @(posedge clk); #1;
      wr_valid = 1'b0;
      wait_frames(f0 + 2, "b2b");
      score_frame("b2b_first");
      score_frame("b2b_second");
      n_checks++;
      if (acc_last - acc_prev !== ACC_PERIOD) begin
         n_fail++;
         $display("FAIL b2b_accept_spacing: got=%0d required=%0d", acc_last - acc_prev, ACC_PERIOD);
      end
      n_checks++;
      if (last_cs_high !== CS_HIGH_B2B) begin
         n_fail++;
         $display("FAIL b2b_cs_high: got=%0d required=%0d", last_cs_high, CS_HIGH_B2B);
      end
      n_checks++;
      if (done_total - d0 !== 2) begin
         n_fail++;
         $display("FAIL b2b_done_count: got=%0d required=2", done_total - d0);
      end
   endtask

   task automatic test_data_change();
      int f0;
      f0 = frames_total;
      send_word(16'h1234);
      @(posedge clk); #1;
      wr_data = 16'hFFFF;
      wr_valid = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      wr_valid = 1'b0;
      wait_frames(f0 + 1, "hold_data");
      score_frame("hold_data");
      n_checks++;
      if (frames_total !== f0 + 1) begin
         n_fail++;
         $display("FAIL hold_data_frames: got=%0d required=%0d", frames_total - f0, 1);
      end
   endtask

   task automatic test_reset_mid_frame();
      int d0, f0, k;
      logic [DW-1:0] dropped;
      d0 = done_total; f0 = frames_total;
      send_word(16'h00FF);
      k = 0;
      while (!(rx_n == 5 && !CS) && k < 400) begin
         @(negedge clk); #1; k++;
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({CS, SCLK, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL abort_pins: got=%b required=100", {CS, SCLK, busy});
      end
      dropped = exp_q.pop_back();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3 * DIV) @(negedge clk);
      #1;
      n_checks++;
      if (done_total !== d0 || frames_total !== f0) begin
         n_fail++;
         $display("FAIL abort_no_done: done=%0d frames=%0d required=0 0 (word %h)",
                  done_total - d0, frames_total - f0, dropped);
      end
      send_word(16'h00FF);
      wait_frames(f0 + 1, "after_abort");
      score_frame("after_abort");
   endtask

   task automatic test_bit_order();
      int f0;
      logic [DW-1:0] got;
      f0 = frames_total;
      send_word(16'h0001);
      wait_frames(f0 + 1, "order");
      got = (rx_q.size() > 0) ? rx_q[0] : '0;
      n_checks++;
`ifdef SPI_WR_LSB_FIRST_EN
      if (got[DW-1] !== 1'b1 || got[DW-2:0] !== '0) begin
`else
      if (got[DW-1:1] !== '0 || got[0] !== 1'b1) begin
`endif
         n_fail++;
         $display("FAIL order_bits: sampled=%b", got);
      end
      score_frame("order");
   endtask

   task automatic test_pin_rules();
      n_checks++;
      if (busy_err !== 0) begin
         n_fail++;
         $display("FAIL busy_cover: got=%0d bad cycles required=0", busy_err);
      end
      n_checks++;
      if (pin_err !== 0) begin
         n_fail++;
         $display("FAIL idle_pins: got=%0d bad cycles required=0", pin_err);
      end
      n_checks++;
      if (mosi_err !== 0) begin
         n_fail++;
         $display("FAIL mosi_stable: got=%0d changes at rise required=0", mosi_err);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_data_change();
      test_reset_mid_frame();
      test_bit_order();
      test_pin_rules();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
